// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - memory request/ready handshake between control unit and memory
interface mips_multicycle_ctrl_if;
    logic mem_read;
    logic mem_write;
    logic iord;
    logic mem_ready;

    modport master (output mem_read, output mem_write, output iord, input mem_ready);
    modport slave  (input mem_read, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory wait timeout and retire counter
module mips_multicycle_ctrl #(
    parameter int WAIT_TIMEOUT = 15,
    parameter int CNT_W        = 32,
    parameter int EN_JUMP      = 1,
    parameter int EN_ADDI      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 zero,
    mips_multicycle_ctrl_if.master mem,
    output logic                 pc_en,
    output logic                 pc_write_cond,
    output logic                 ir_write,
    output logic                 mem2reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic [3:0]           state,
    output logic                 instr_done,
    output logic [CNT_W-1:0]     retired,
    output logic                 illegal,
    output logic                 bus_error
);
    // The wait counter only has to reach WAIT_TIMEOUT-1; the next stalled cycle errors out.
    localparam int TW    = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam int LIMIT = (WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_ERROR  = 4'd15
    } state_t;

    state_t        cur, nxt;
    logic [TW-1:0] wait_cnt;
    logic          limit_hit, waiting, decode_bad;
    logic          pc_write, pcwc_raw, ir_write_raw, reg_write_raw;
    logic          mem_read_raw, mem_write_raw, done_raw;

    assign limit_hit = (WAIT_TIMEOUT > 0) && (wait_cnt == TW'(LIMIT));

    always_comb begin
        nxt           = cur;
        waiting       = 1'b0;
        decode_bad    = 1'b0;
        pc_write      = 1'b0;
        pcwc_raw      = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        done_raw      = 1'b0;
        mem.iord      = 1'b0;
        mem2reg       = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (cur)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                waiting      = 1'b1;
                if (mem.mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write     = 1'b1;
                    alu_src_b    = 2'b01;
                    nxt          = S_DECODE;
                end else if (limit_hit) begin
                    nxt = S_ERROR;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    6'b100011, 6'b101011: nxt = S_MEMADR;
                    6'b000000:            nxt = S_EXEC;
                    6'b000100:            nxt = S_BRANCH;
                    6'b000010: begin
                        nxt        = (EN_JUMP != 0) ? S_JUMP : S_ERROR;
                        decode_bad = (EN_JUMP == 0);
                    end
                    6'b001000: begin
                        nxt        = (EN_ADDI != 0) ? S_ADDIEX : S_ERROR;
                        decode_bad = (EN_ADDI == 0);
                    end
                    default: begin
                        nxt        = S_ERROR;
                        decode_bad = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read_raw = 1'b1;
                mem.iord     = 1'b1;
                waiting      = 1'b1;
                if (mem.mem_ready) nxt = S_MEMWB;
                else if (limit_hit) nxt = S_ERROR;
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                mem2reg       = 1'b1;
                done_raw      = 1'b1;
                nxt           = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_raw = 1'b1;
                mem.iord      = 1'b1;
                waiting       = 1'b1;
                if (mem.mem_ready) begin
                    done_raw = 1'b1;
                    nxt      = S_FETCH;
                end else if (limit_hit) begin
                    nxt = S_ERROR;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
                done_raw      = 1'b1;
                nxt           = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pcwc_raw  = 1'b1;
                done_raw  = 1'b1;
                nxt       = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                done_raw  = 1'b1;
                nxt       = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                nxt           = S_FETCH;
            end
            default: nxt = S_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= S_FETCH;
            wait_cnt  <= '0;
            retired   <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            cur <= nxt;
            if (mem.mem_ready || nxt != cur) wait_cnt <= '0;
            else if (waiting) wait_cnt <= wait_cnt + TW'(1);
            if (done_raw) retired <= retired + CNT_W'(1);
            if (decode_bad) illegal <= 1'b1;
            if (waiting && !mem.mem_ready && limit_hit) bus_error <= 1'b1;
        end
    end

    // Reset cycles must never commit anything to the datapath or memory.
    assign pc_en         = !reset && (pc_write || (pcwc_raw && zero));
    assign pc_write_cond = !reset && pcwc_raw;
    assign ir_write      = !reset && ir_write_raw;
    assign reg_write     = !reset && reg_write_raw;
    assign mem.mem_read  = !reset && mem_read_raw;
    assign mem.mem_write = !reset && mem_write_raw;
    assign instr_done    = !reset && done_raw;
    assign state         = cur;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed bench with a sequence-level model of two controller configurations
module tb_mips_multicycle_ctrl;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    logic clk = 1'b0, reset = 1'b1, zero = 1'b0, rdy = 1'b0;
    logic [5:0] opcode = 6'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus_a ();
    mips_multicycle_ctrl_if bus_b ();
    assign bus_a.mem_ready = rdy;
    assign bus_b.mem_ready = rdy;

    logic a_pc_en, a_pwc, a_irw, a_m2r, a_rd, a_rw, a_asa, a_done, a_ill, a_berr;
    logic [1:0] a_asb, a_aop, a_psrc;
    logic [3:0] a_state;
    logic [31:0] a_ret;
    logic b_pc_en, b_pwc, b_irw, b_m2r, b_rd, b_rw, b_asa, b_done, b_ill, b_berr;
    logic [1:0] b_asb, b_aop, b_psrc;
    logic [3:0] b_state;
    logic [3:0] b_ret;

    mips_multicycle_ctrl dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem(bus_a.master),
        .pc_en(a_pc_en), .pc_write_cond(a_pwc), .ir_write(a_irw), .mem2reg(a_m2r),
        .reg_dst(a_rd), .reg_write(a_rw), .alu_src_a(a_asa), .alu_src_b(a_asb),
        .alu_op(a_aop), .pc_source(a_psrc), .state(a_state), .instr_done(a_done),
        .retired(a_ret), .illegal(a_ill), .bus_error(a_berr)
    );

    mips_multicycle_ctrl #(.WAIT_TIMEOUT(3), .CNT_W(4), .EN_JUMP(0), .EN_ADDI(1)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem(bus_b.master),
        .pc_en(b_pc_en), .pc_write_cond(b_pwc), .ir_write(b_irw), .mem2reg(b_m2r),
        .reg_dst(b_rd), .reg_write(b_rw), .alu_src_a(b_asa), .alu_src_b(b_asb),
        .alu_op(b_aop), .pc_source(b_psrc), .state(b_state), .instr_done(b_done),
        .retired(b_ret), .illegal(b_ill), .bus_error(b_berr)
    );

    logic [22:0] act_a, act_b;
    assign act_a = {a_state, a_pc_en, a_pwc, bus_a.iord, bus_a.mem_read, bus_a.mem_write, a_irw,
                    a_m2r, a_rd, a_rw, a_asa, a_asb, a_aop, a_psrc, a_done, a_ill, a_berr};
    assign act_b = {b_state, b_pc_en, b_pwc, bus_b.iord, bus_b.mem_read, bus_b.mem_write, b_irw,
                    b_m2r, b_rd, b_rw, b_asa, b_asb, b_aop, b_psrc, b_done, b_ill, b_berr};

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each instruction is a list of post-decode states; memory states stall until ready.
    int    wt[2] = '{15, 3};
    int    ej[2] = '{1, 0};
    int    cw[2] = '{32, 4};
    int    m_st[2], m_pos[2], m_len[2], m_wc[2];
    int    m_seq[2][3];
    longint m_ret[2];
    bit    m_ill[2], m_berr[2];
    bit    valid = 1'b0;

    function automatic bit is_mem(int st);
        return st == 0 || st == 3 || st == 5;
    endfunction

    function automatic logic [15:0] ctl(int st, logic r, logic z, logic rst);
        logic pe, pwc, io, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, ps;
        {pe, pwc, io, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            0:  begin mr = 1; if (r) begin irw = 1; pe = 1; asb = 2'b01; end end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; ps = 2'b01; pwc = 1; pe = z; end
            9:  begin ps = 2'b10; pe = 1; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        if (rst) {pe, pwc, irw, rw, mr, mw} = '0;
        return {pe, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps};
    endfunction

    function automatic logic [22:0] exp_vec(int k);
        bit done;
        done = !reset && m_st[k] > 1 && m_st[k] != 15 && m_pos[k] == m_len[k] - 1
               && (!is_mem(m_st[k]) || rdy);
        return {4'(m_st[k]), ctl(m_st[k], rdy, zero, reset), done, m_ill[k], m_berr[k]};
    endfunction

    task automatic set_seq(int k, int len, int s0, int s1, int s2);
        m_len[k] = len; m_pos[k] = 0;
        m_seq[k][0] = s0; m_seq[k][1] = s1; m_seq[k][2] = s2;
        m_st[k] = s0;
    endtask

    task automatic advance(int k);
        longint mask;
        mask = (cw[k] == 32) ? 64'hFFFF_FFFF : ((64'd1 << cw[k]) - 1);
        if (reset) begin
            m_st[k] = 0; m_ret[k] = 0; m_ill[k] = 0; m_berr[k] = 0;
            m_wc[k] = 0; m_pos[k] = 0; m_len[k] = 0;
        end else if (m_st[k] == 15) begin
            m_st[k] = 15;
        end else if (m_st[k] == 1) begin
            m_wc[k] = 0;
            if (opcode == OP_LW)                       set_seq(k, 3, 2, 3, 4);
            else if (opcode == OP_SW)                  set_seq(k, 2, 2, 5, 0);
            else if (opcode == OP_R)                   set_seq(k, 2, 6, 7, 0);
            else if (opcode == OP_BEQ)                 set_seq(k, 1, 8, 0, 0);
            else if (opcode == OP_J && ej[k] != 0)     set_seq(k, 1, 9, 0, 0);
            else if (opcode == OP_ADDI)                set_seq(k, 2, 10, 11, 0);
            else begin m_st[k] = 15; m_ill[k] = 1; end
        end else if (is_mem(m_st[k]) && !rdy) begin
            m_wc[k]++;
            if (wt[k] > 0 && m_wc[k] == wt[k]) begin m_st[k] = 15; m_berr[k] = 1; end
        end else begin
            m_wc[k] = 0;
            if (m_st[k] == 0) m_st[k] = 1;
            else begin
                m_pos[k]++;
                if (m_pos[k] == m_len[k]) begin
                    m_st[k] = 0;
                    m_ret[k] = (m_ret[k] + 1) & mask;
                end else m_st[k] = m_seq[k][m_pos[k]];
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        #3;
        if (valid) begin
            chk("cycle_a", act_a, exp_vec(0));
            chk("retired_a", a_ret, m_ret[0][31:0]);
            chk("cycle_b", act_b, exp_vec(1));
            chk("retired_b", b_ret, m_ret[1][3:0]);
        end
        advance(0);
        advance(1);
        if (reset) valid = 1'b1;
    end

    int q_st[$];
    bit log_en = 1'b0;

    task automatic step(input logic r, input logic [5:0] op, input logic z, input logic rd);
        @(negedge clk);
        #1;
        reset = r; opcode = op; zero = z; rdy = rd;
        #3;
        if (log_en) q_st.push_back(int'(a_state));
    endtask

    task automatic do_reset();
        step(1, 6'b0, 0, 0);
        step(1, 6'b0, 0, 0);
    endtask

    task automatic instr(input logic [5:0] op, input logic z, input int fw, input int mw, output int n);
        int rest, mi;
        n = 0;
        repeat (fw) begin step(0, op, z, 0); n++; end
        step(0, op, z, 1); n++;
        step(0, op, z, 0); n++;
        rest = (op == OP_LW) ? 3 : (op == OP_BEQ || op == OP_J) ? 1 : 2;
        mi = (op == OP_LW || op == OP_SW) ? 1 : -1;
        for (int i = 0; i < rest; i++) begin
            if (i == mi) begin
                repeat (mw) begin step(0, op, z, 0); n++; end
                step(0, op, z, 1); n++;
            end else begin
                step(0, op, z, 0); n++;
            end
        end
    endtask

    initial begin
        int n;
        int exp_seq[8] = '{0, 1, 6, 7, 0, 1, 2, 5};

        do_reset();
        chk("reset_state", a_state, 4'd0);
        chk("reset_retired", a_ret, 32'd0);
        chk("reset_flags", {a_ill, a_berr, b_ill, b_berr}, 4'b0);

        instr(OP_LW, 0, 2, 2, n);
        chk("lw_cycles", n, 9);
        chk("lw_done", a_done, 1'b1);
        chk("lw_wb", {a_rw, a_m2r, a_rd}, 3'b110);
        step(0, OP_LW, 0, 0);
        chk("lw_retired", a_ret, 32'd1);

        do_reset();
        log_en = 1'b1;
        instr(OP_R, 0, 0, 0, n);
        instr(OP_SW, 0, 0, 0, n);
        log_en = 1'b0;
        chk("sw_memwr", {bus_a.mem_write, bus_a.iord, a_done}, 3'b111);
        for (int i = 0; i < 8; i++) chk($sformatf("seq_%0d", i), q_st[i], exp_seq[i]);
        step(0, OP_R, 0, 0);
        chk("rsw_retired", a_ret, 32'd2);

        do_reset();
        instr(OP_BEQ, 1, 0, 0, n);
        chk("beq_taken_pcen", {a_pc_en, a_pwc, a_done}, 3'b111);
        instr(OP_BEQ, 0, 0, 0, n);
        chk("beq_nt_pcen", {a_pc_en, a_pwc, a_done}, 3'b011);
        instr(OP_ADDI, 0, 0, 0, n);
        chk("addi_wb", {a_rw, a_rd, a_m2r, a_done}, 4'b1001);
        step(0, OP_R, 0, 0);
        chk("beq_addi_retired", a_ret, 32'd3);

        do_reset();
        repeat (3) step(0, OP_R, 0, 0);
        step(0, OP_R, 0, 1);
        chk("timeout_state_b", b_state, 4'd15);
        chk("timeout_flag_b", {b_berr, bus_b.mem_read, b_irw, b_pc_en}, 4'b1000);
        chk("timeout_a_ok", {a_state, a_berr, a_irw}, 6'b000001);
        repeat (2) step(0, OP_R, 0, 1);
        chk("error_held_b", {b_state, b_berr}, 5'b11111);

        do_reset();
        instr(6'b111111, 0, 0, 0, n);
        chk("illegal_state", {a_state, a_ill, b_state, b_ill}, 10'b1111_1_1111_1);
        do_reset();
        chk("illegal_cleared", a_ill, 1'b0);
        instr(OP_J, 0, 0, 0, n);
        chk("j_a", {a_state, a_pc_en, a_psrc, a_done}, 8'b1001_1_10_1);
        chk("j_b_illegal", {b_state, b_ill}, 5'b11111);

        do_reset();
        step(0, OP_LW, 0, 1);
        step(0, OP_LW, 0, 0);
        step(0, OP_LW, 0, 0);
        step(0, OP_LW, 0, 0);
        chk("abort_in_memrd", a_state, 4'd3);
        step(1, OP_LW, 0, 1);
        chk("abort_gated", {bus_a.mem_read, a_done, a_rw}, 3'b000);
        step(0, OP_LW, 0, 0);
        chk("abort_after", {a_state, a_ret[3:0], a_ill, a_berr}, 10'b0);

        do_reset();
        repeat (16) instr(OP_BEQ, 0, 0, 0, n);
        step(0, OP_R, 0, 0);
        chk("wrap_b", b_ret, 4'd0);
        chk("no_wrap_a", a_ret, 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
